scan_sequencer: RTL

- Upstream driver for the 3-to-8 one-hot decoder: generates the 3-bit select {sel_a, sel_b, sel_c} that steps through positions 0..7 at a programmable rate.
- Used for LED and digit scanning and for sequenced enables.
- Supports continuous or single-sweep operation, up or down direction, pause via enable, and per-step and wrap pulses for downstream logic.

---
 rtl/scan_pkg.sv | 10 +
 rtl/scan_prescaler.sv | 32 +++
 rtl/scan_sequencer.sv | 85 ++++++++
 3 files changed

// File: rtl/scan_pkg.sv
// rtl/scan_pkg.sv - shared state type and index constants for the scan sequencer
package scan_pkg;
    localparam int IDX_W = 3;
    localparam logic [IDX_W-1:0] IDX_MAX = 3'd7;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;
endpackage

// File: rtl/scan_prescaler.sv
// rtl/scan_prescaler.sv - dwell divider; pulses step once the count reaches div
module scan_prescaler #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    output logic             step
);
    logic [DIV_W-1:0] cnt_q, cnt_d;

    // >= rather than == so lowering div below the count steps at once instead of rolling over
    always_comb begin
        step  = en && !clr && (cnt_q >= div);
        cnt_d = cnt_q;
        if (clr || step) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/scan_sequencer.sv
// rtl/scan_sequencer.sv - 3-bit scan index generator with programmable dwell, sweep modes and step/wrap pulses
module scan_sequencer
    import scan_pkg::*;
#(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             en,
    input  logic             dir,
    input  logic             mode,
    input  logic [DIV_W-1:0] div,
    output logic             sel_a,
    output logic             sel_b,
    output logic             sel_c,
    output logic             busy,
    output logic             tick,
    output logic             wrap
);
    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             dir_q, dir_d;
    logic             mode_q, mode_d;
    logic             tick_q, tick_d;
    logic             wrap_q, wrap_d;
    logic             step;

    scan_prescaler #(.DIV_W(DIV_W)) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (start || (state_q == IDLE)),
        .en    (en && (state_q == RUN)),
        .div   (div),
        .step  (step)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        dir_d   = dir_q;
        mode_d  = mode_q;
        tick_d  = 1'b0;
        wrap_d  = 1'b0;
        if (start) begin
            state_d = RUN;
            idx_d   = dir ? IDX_MAX : '0;
            dir_d   = dir;
            mode_d  = mode;
        end else if ((state_q == RUN) && step) begin
            tick_d = 1'b1;
            idx_d  = dir_q ? (idx_q - 1'b1) : (idx_q + 1'b1);
            wrap_d = dir_q ? (idx_q == '0) : (idx_q == IDX_MAX);
            // the natural wrap lands on the sweep's start value, so single mode only needs to stop
            if (wrap_d && mode_q) begin
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            dir_q   <= 1'b0;
            mode_q  <= 1'b0;
            tick_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            dir_q   <= dir_d;
            mode_q  <= mode_d;
            tick_q  <= tick_d;
            wrap_q  <= wrap_d;
        end
    end

    assign sel_a = idx_q[2];
    assign sel_b = idx_q[1];
    assign sel_c = idx_q[0];
    assign busy  = (state_q == RUN);
    assign tick  = tick_q;
    assign wrap  = wrap_q;
endmodule
